// File: rtl/gc_buf_pkg.sv
// Shared types and sizing helpers for the garbled-circuit label buffers.
// NR_AES is the single source of the AES pipeline latency.
package gc_buf_pkg;

    typedef logic [127:0] label_t;

    localparam int unsigned NR_AES = 4;

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 32'd1);
    endfunction

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 32'd1) ? $clog2(depth) : 32'd1;
    endfunction

endpackage

// File: rtl/aes_result_drain_if.sv
// Handshake bundle between the AES issuer/pipeline, the result drain and its consumer.
// Defining RESULT_LAT_CHECK_EN adds the lat_err status signal.
interface aes_result_drain_if #(
    parameter int unsigned N     = 128,
    parameter int unsigned DEPTH = 16
);
    import gc_buf_pkg::*;

    localparam int unsigned CW = cnt_w(DEPTH);

    logic          issue_req;
    logic          issue_gnt;
    logic          res_valid;
    logic [N-1:0]  res_data;
    logic          out_valid;
    logic [N-1:0]  out_data;
    logic          out_ready;
    logic [CW-1:0] occupancy;
    logic          overflow;

`ifdef RESULT_LAT_CHECK_EN
    logic          lat_err;

    modport master (
        output issue_req, res_valid, res_data, out_ready,
        input  issue_gnt, out_valid, out_data, occupancy, overflow, lat_err
    );

    modport slave (
        input  issue_req, res_valid, res_data, out_ready,
        output issue_gnt, out_valid, out_data, occupancy, overflow, lat_err
    );
`else
    modport master (
        output issue_req, res_valid, res_data, out_ready,
        input  issue_gnt, out_valid, out_data, occupancy, overflow
    );

    modport slave (
        input  issue_req, res_valid, res_data, out_ready,
        output issue_gnt, out_valid, out_data, occupancy, overflow
    );
`endif

endinterface

// File: rtl/aes_result_drain_result_ram.sv
// DEPTH x N result storage: one synchronous write port, asynchronous read,
// contents cleared by the asynchronous reset.
module result_ram
    import gc_buf_pkg::*;
#(
    parameter int unsigned N     = 128,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PW    = ptr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [PW-1:0] waddr_i,
    input  logic [N-1:0]  wdata_i,
    input  logic [PW-1:0] raddr_i,
    output logic [N-1:0]  rdata_o
);

    logic [N-1:0] mem_q [DEPTH];

    // Storage array write; reset wipes every entry so out_data reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= {N{1'b0}};
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/aes_result_drain.sv
// Credit-gated result FIFO at the output of the fixed-latency AES label pipeline.
// Optional macro RESULT_LAT_CHECK_EN adds an issue-to-result latency checker (lat_err).
module aes_result_drain
    import gc_buf_pkg::*;
#(
    parameter int unsigned N       = 128,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned AES_LAT = NR_AES
) (
    input  logic              clk,
    input  logic              rst,
    aes_result_drain_if.slave bus
);

    localparam int unsigned   CW     = cnt_w(DEPTH);
    localparam int unsigned   PW     = ptr_w(DEPTH);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C  = CW'(1'b1);
    localparam logic [PW-1:0] PONE_C = PW'(1'b1);

    if ((DEPTH < 32'd2) || ((DEPTH & (DEPTH - 32'd1)) != 32'd0) || (AES_LAT < 32'd1)) begin : g_bad_cfg
        $error("aes_result_drain: DEPTH must be a power of 2 >= 2 and AES_LAT >= 1");
    end

    logic [CW-1:0] credits_q, credits_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;

    logic          issue_gnt_s, issue_s, out_valid_s, pop_s;
    logic          full_s, push_s, drop_s;
    logic [N-1:0]  rdata_s;

    assign issue_gnt_s = (credits_q != ZERO_C);
    assign issue_s     = bus.issue_req & issue_gnt_s;
    assign out_valid_s = (occ_q != ZERO_C);
    assign pop_s       = out_valid_s & bus.out_ready;
    assign full_s      = (occ_q == FULL_C);
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign push_s      = bus.res_valid & (~full_s | pop_s);
    assign drop_s      = bus.res_valid & full_s & ~pop_s;

    // Credit and fill-level updates; both saturate rather than wrap.
    always_comb begin
        credits_d = credits_q;
        occ_d     = occ_q;
        if (issue_s && !pop_s) begin
            credits_d = (credits_q != ZERO_C) ? (credits_q - ONE_C) : credits_q;
        end else if (pop_s && !issue_s) begin
            credits_d = (credits_q != FULL_C) ? (credits_q + ONE_C) : credits_q;
        end else begin
            credits_d = credits_q;
        end
        if (push_s && !pop_s) begin
            occ_d = (occ_q != FULL_C) ? (occ_q + ONE_C) : occ_q;
        end else if (pop_s && !push_s) begin
            occ_d = (occ_q != ZERO_C) ? (occ_q - ONE_C) : occ_q;
        end else begin
            occ_d = occ_q;
        end
    end

    // Pointer advance (power-of-two depth wraps naturally) and sticky overflow.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q | drop_s;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PONE_C;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PONE_C;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits_q  <= FULL_C;
            occ_q      <= ZERO_C;
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            credits_q  <= credits_d;
            occ_q      <= occ_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    result_ram #(
        .N     (N),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (push_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.res_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata_s)
    );

    assign bus.issue_gnt = issue_gnt_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_data  = rdata_s;
    assign bus.occupancy = occ_q;
    assign bus.overflow  = overflow_q;

`ifdef RESULT_LAT_CHECK_EN
    logic [AES_LAT-1:0] lat_sr_q, lat_sr_d;
    logic               lat_err_q, lat_err_d;

    // Delay line of accepted issues; its last tap says a result is due now.
    always_comb begin
        lat_sr_d  = AES_LAT'({lat_sr_q, issue_s});
        lat_err_d = lat_err_q | (bus.res_valid != lat_sr_q[AES_LAT-1]);
    end

    // Latency checker registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_sr_q  <= {AES_LAT{1'b0}};
            lat_err_q <= 1'b0;
        end else begin
            lat_sr_q  <= lat_sr_d;
            lat_err_q <= lat_err_d;
        end
    end

    assign bus.lat_err = lat_err_q;
`endif

endmodule

// File: tb/tb_aes_result_drain.sv
// Scoreboard bench for aes_result_drain: an issuer/pipeline model feeds the DUT and an
// independent monitor checks every handshake against queue and counter models.
module tb_aes_result_drain;
    import gc_buf_pkg::*;

    localparam int unsigned N       = 128;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned AES_LAT = NR_AES;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_result_drain_if #(.N(N), .DEPTH(DEPTH)) bus ();

    aes_result_drain #(
        .N       (N),
        .DEPTH   (DEPTH),
        .AES_LAT (AES_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int     n_chk = 0;
    int     n_err = 0;
    label_t sb [$];
    int     model_occ;
    int     model_cred;
    bit     model_ovf;
    bit     chk_en = 1'b0;
    bit     last_issue;
    int     n_grant;
    int     n_pop;
    int     gnt_low;
    bit     dead_seen;
    bit     pv [AES_LAT];
    label_t pd [AES_LAT];
    label_t seq;
    label_t head_exp;

    task automatic chk(input string name, input label_t act, input label_t exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        sb.delete();
        for (int i = 0; i < int'(AES_LAT); i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
        end
        model_occ  = 0;
        model_cred = int'(DEPTH);
        model_ovf  = 1'b0;
        last_issue = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.issue_req = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_data  = '0;
        bus.out_ready = 1'b0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
        chk_en = 1'b1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // One cycle of issuer + fixed-latency pipeline; inj forces an unsolicited result.
    task automatic step(input bit ir, input bit orr, input bit inj, input label_t inj_d);
        @(posedge clk);
        #1;
        for (int i = int'(AES_LAT) - 1; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        pv[0] = last_issue;
        if (last_issue) begin
            seq   = seq + 1;
            pd[0] = seq;
        end
        if (inj) begin
            bus.res_valid = 1'b1;
            bus.res_data  = inj_d;
        end else begin
            bus.res_valid = pv[AES_LAT-1];
            bus.res_data  = pv[AES_LAT-1] ? pd[AES_LAT-1] : '0;
            if (pv[AES_LAT-1]) sb.push_back(pd[AES_LAT-1]);
        end
        bus.issue_req = ir;
        bus.out_ready = orr;
    endtask

    bit mon_pop, mon_iss, mon_acc;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("issue_gnt", N'(bus.issue_gnt), N'(model_cred != 0));
            chk("out_valid", N'(bus.out_valid), N'(model_occ != 0));
            chk("occupancy", N'(bus.occupancy), N'(model_occ));
            chk("overflow", N'(bus.overflow), N'(model_ovf));
            mon_pop = bus.out_valid & bus.out_ready;
            mon_iss = bus.issue_req & bus.issue_gnt;
            if (mon_pop) begin
                n_pop++;
                if (bus.out_data == N'(16'hDEAD)) dead_seen = 1'b1;
                if (sb.size() == 0) begin
                    chk("pop_with_empty_scoreboard", N'(1'b1), N'(1'b0));
                end else begin
                    chk("out_data", bus.out_data, sb.pop_front());
                end
            end
            mon_acc = bus.res_valid & ((model_occ < int'(DEPTH)) | mon_pop);
            if (bus.res_valid && !mon_acc) model_ovf = 1'b1;
            model_occ  = model_occ + int'(mon_acc) - int'(mon_pop);
            model_cred = model_cred - int'(mon_iss) + int'(mon_pop);
            last_issue = mon_iss;
            n_grant    = n_grant + int'(mon_iss);
            if (!bus.issue_gnt) gnt_low++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        seq       = '0;
        dead_seen = 1'b0;
        n_grant   = 0;
        n_pop     = 0;
        gnt_low   = 0;
        clear_model();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        release_reset();

        settle();
        chk("reset_issue_gnt", N'(bus.issue_gnt), N'(1'b1));
        chk("reset_out_valid", N'(bus.out_valid), N'(1'b0));
        chk("reset_occupancy", N'(bus.occupancy), N'(1'b0));
        chk("reset_overflow", N'(bus.overflow), N'(1'b0));
        chk("reset_out_data", bus.out_data, N'(1'b0));

        // Back-to-back stream: data 0x1..0x14 in order, grant never drops.
        n_pop   = 0;
        gnt_low = 0;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, '0);
        settle();
        chk("b2b_pops", N'(n_pop), N'(20));
        chk("b2b_gnt_low_cycles", N'(gnt_low), N'(0));
        chk("b2b_last_seq", seq, N'(8'h14));

        // Backpressure: exactly DEPTH grants, then one more per single pop.
        n_grant = 0;
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b0, '0);
        settle();
        chk("bp_grants", N'(n_grant), N'(DEPTH));
        chk("bp_occupancy", N'(bus.occupancy), N'(DEPTH));
        chk("bp_gnt_low", N'(bus.issue_gnt), N'(1'b0));
        step(1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, '0);
        settle();
        chk("bp_one_more_grant", N'(n_grant), N'(DEPTH + 1));
        chk("bp_overflow", N'(bus.overflow), N'(1'b0));
        for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b0, '0);

        // Wrap-around pattern, then random traffic.
        for (int i = 0; i < 40; i++) step((i % 5) < 3, (i % 5) >= 3, 1'b0, '0);
        for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, '0);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0, '0);
        settle();
        chk("drain_scoreboard_empty", N'(sb.size()), N'(0));
        chk("drain_occupancy", N'(bus.occupancy), N'(0));

        // Forced overflow: 0xDEAD is dropped and the head stays put.
        for (int i = 0; i < 25; i++) step(1'b1, 1'b0, 1'b0, '0);
        head_exp = sb[0];
        step(1'b0, 1'b0, 1'b1, N'(16'hDEAD));
        step(1'b0, 1'b0, 1'b0, '0);
        settle();
        chk("ovf_flag", N'(bus.overflow), N'(1'b1));
        chk("ovf_head", bus.out_data, head_exp);
        chk("ovf_occupancy", N'(bus.occupancy), N'(DEPTH));
        for (int i = 0; i < 25; i++) step(1'b0, 1'b1, 1'b0, '0);
        settle();
        chk("ovf_dead_never_seen", N'(dead_seen), N'(1'b0));
        chk("ovf_drained", N'(sb.size()), N'(0));

        // Asynchronous reset mid-stream with five entries stored.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, '0);
        settle();
        chk("mid_occupancy", N'(bus.occupancy), N'(5));
        @(posedge clk);
        #3;
        chk_en = 1'b0;
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("mid_rst_issue_gnt", N'(bus.issue_gnt), N'(1'b1));
        chk("mid_rst_out_valid", N'(bus.out_valid), N'(1'b0));
        chk("mid_rst_occupancy", N'(bus.occupancy), N'(0));
        chk("mid_rst_out_data", bus.out_data, N'(0));
        chk("mid_rst_overflow", N'(bus.overflow), N'(1'b0));
`ifdef RESULT_LAT_CHECK_EN
        chk("mid_rst_lat_err", N'(bus.lat_err), N'(1'b0));
`endif
        release_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, '0);

`ifdef RESULT_LAT_CHECK_EN
        // Result one cycle early is flagged; on time is accepted.
        chk_en = 1'b0;
        idle_inputs();
        @(posedge clk); #1; bus.issue_req = 1'b1;
        @(posedge clk); #1; bus.issue_req = 1'b0;
        repeat (2) @(posedge clk);
        #1; bus.res_valid = 1'b1; bus.res_data = N'(8'h55);
        @(posedge clk); #1; bus.res_valid = 1'b0;
        settle();
        chk("lat_early", N'(bus.lat_err), N'(1'b1));
        rst = 1'b1;
        #2;
        rst = 1'b0;
        idle_inputs();
        @(posedge clk); #1; bus.issue_req = 1'b1;
        @(posedge clk); #1; bus.issue_req = 1'b0;
        repeat (3) @(posedge clk);
        #1; bus.res_valid = 1'b1; bus.res_data = N'(8'h66);
        @(posedge clk); #1; bus.res_valid = 1'b0;
        settle();
        chk("lat_on_time", N'(bus.lat_err), N'(1'b0));
        repeat (3) @(posedge clk);
        settle();
        chk("lat_on_time_later", N'(bus.lat_err), N'(1'b0));
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
